// File: rtl/system_bus_pkg.sv
// Shared widths and types for the cpu system bus and its router.
package system_bus_pkg;

   localparam int ADDR_WIDTH        = 30;
   localparam int DATA_WIDTH        = 32;
   localparam int BYTE_ENABLE_WIDTH = 4;

   typedef logic [ADDR_WIDTH-1:0]        bus_addr_t;
   typedef logic [DATA_WIDTH-1:0]        bus_data_t;
   typedef logic [BYTE_ENABLE_WIDTH-1:0] bus_be_t;

   // Width of a counter that must hold 0..max_outstanding inclusive.
   function automatic int cnt_width(input int max_outstanding);
      return $clog2(max_outstanding + 1);
   endfunction

endpackage

// File: rtl/system_bus_router_if.sv
// cpu-side system bus: the master drives requests, the router answers.
interface system_bus_router_if;
   import system_bus_pkg::*;

   logic      bus_ready;
   bus_addr_t bus_addr;
   bus_data_t bus_write_data;
   bus_be_t   bus_byte_enable;
   logic      bus_write_req;
   logic      bus_read_req;
   bus_data_t bus_read_data;
   logic      bus_read_data_valid;

   modport master (
      output bus_addr, bus_write_data, bus_byte_enable, bus_write_req, bus_read_req,
      input  bus_ready, bus_read_data, bus_read_data_valid
   );

   modport slave (
      input  bus_addr, bus_write_data, bus_byte_enable, bus_write_req, bus_read_req,
      output bus_ready, bus_read_data, bus_read_data_valid
   );

endinterface

// File: rtl/system_bus_router_read_order_tracker.sv
// Keeps reads in order: all reads in flight target one slave, so data can
// only come back in request order. Counts outstanding reads and remembers
// which slave owns them.
module read_order_tracker
   import system_bus_pkg::*;
#(
   parameter int SEL_BITS        = 2,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CNT_W          = cnt_width(MAX_OUTSTANDING),
   localparam int NUM_IDX        = 2**SEL_BITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [SEL_BITS-1:0] sel,
   input  logic                rd_req,
   input  logic                sel_ready,
   input  logic [NUM_IDX-1:0]  ret_valid_vec,
   output logic                rd_stall,
   output logic                ret_valid,
   output logic [SEL_BITS-1:0] active_slave
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0]    rd_count_d, rd_count_q;
   logic [SEL_BITS-1:0] active_slave_d, active_slave_q;
   logic                rd_accept;

   // Stall when full or when a new read would switch slaves mid-flight.
   always_comb begin
      rd_stall       = (rd_count_q == CNT_MAX) |
                       ((rd_count_q != '0) & (sel != active_slave_q));
      rd_accept      = rd_req & sel_ready & ~rd_stall;
      ret_valid      = ret_valid_vec[active_slave_q] & (rd_count_q != '0);
      rd_count_d     = rd_count_q;
      active_slave_d = active_slave_q;
      if (rd_accept) begin
         active_slave_d = sel;
      end
      case ({rd_accept, ret_valid})
         2'b10:   rd_count_d = rd_count_q + CNT_W'(1);
         2'b01:   rd_count_d = rd_count_q - CNT_W'(1);
         default: rd_count_d = rd_count_q;
      endcase
   end

   // Outstanding-read state, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_count_q     <= '0;
         active_slave_q <= '0;
      end else begin
         rd_count_q     <= rd_count_d;
         active_slave_q <= active_slave_d;
      end
   end

   assign active_slave = active_slave_q;

endmodule

// File: rtl/system_bus_router.sv
// cpu system bus router: decodes the top word-address bits into a slave
// index, fans requests out with no added latency and returns read data in
// request order.
// Optional feature: define SYSTEM_BUS_ROUTER_DEFAULT_SLAVE_EN to answer
// unmapped indices with an internal always-ready slave (writes dropped,
// reads return zero one cycle after accept). Without it an unmapped access
// is never accepted.
module system_bus_router
   import system_bus_pkg::*;
#(
   parameter int NUM_SLAVES      = 4,
   parameter int SEL_BITS        = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   system_bus_router_if.slave             cpu_bus,
   output bus_addr_t                      slave_addr,
   output bus_data_t                      slave_write_data,
   output bus_be_t                        slave_byte_enable,
   output logic [NUM_SLAVES-1:0]          slave_write_req,
   output logic [NUM_SLAVES-1:0]          slave_read_req,
   input  logic [NUM_SLAVES-1:0]          slave_ready,
   input  logic [DATA_WIDTH*NUM_SLAVES-1:0] slave_read_data,
   input  logic [NUM_SLAVES-1:0]          slave_read_data_valid
);

   localparam int NUM_IDX = 2**SEL_BITS;

   logic [SEL_BITS-1:0] sel;
   logic                mapped;
   logic                rd_stall;
   logic                ret_valid;
   logic [SEL_BITS-1:0] active_slave;
   logic [NUM_IDX-1:0]  ext_ready;
   logic [NUM_IDX-1:0]  ext_valid;
   bus_data_t           ext_data [NUM_IDX];

   assign sel    = cpu_bus.bus_addr[ADDR_WIDTH-1 -: SEL_BITS];
   assign mapped = (int'(sel) < NUM_SLAVES);

   // Every index gets a ready/valid/data source: a real slave, the default
   // slave, or a dead entry that is never ready.
   for (genvar i = 0; i < NUM_IDX; i++) begin : g_idx
      if (i < NUM_SLAVES) begin : g_real
         assign ext_ready[i] = slave_ready[i];
         assign ext_valid[i] = slave_read_data_valid[i];
         assign ext_data[i]  = slave_read_data[DATA_WIDTH*i +: DATA_WIDTH];
      end else begin : g_unmapped
`ifdef SYSTEM_BUS_ROUTER_DEFAULT_SLAVE_EN
         logic dflt_valid_d, dflt_valid_q;

         // Default slave answers every accepted read on the following cycle.
         always_comb begin
            dflt_valid_d = cpu_bus.bus_read_req & cpu_bus.bus_ready &
                           (sel == SEL_BITS'(i));
         end

         // Response pipeline stage of the default slave.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               dflt_valid_q <= 1'b0;
            end else begin
               dflt_valid_q <= dflt_valid_d;
            end
         end

         assign ext_ready[i] = 1'b1;
         assign ext_valid[i] = dflt_valid_q;
         assign ext_data[i]  = '0;
`else
         assign ext_ready[i] = 1'b0;
         assign ext_valid[i] = 1'b0;
         assign ext_data[i]  = '0;
`endif
      end
   end

   read_order_tracker #(
      .SEL_BITS        (SEL_BITS),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_tracker (
      .clk           (clk),
      .reset_n       (reset_n),
      .sel           (sel),
      .rd_req        (cpu_bus.bus_read_req),
      .sel_ready     (ext_ready[sel]),
      .ret_valid_vec (ext_valid),
      .rd_stall      (rd_stall),
      .ret_valid     (ret_valid),
      .active_slave  (active_slave)
   );

   // One-hot request fan-out; a stalled read reaches no slave.
   always_comb begin
      slave_write_req = '0;
      slave_read_req  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         slave_write_req[i] = cpu_bus.bus_write_req & mapped & (sel == SEL_BITS'(i));
         slave_read_req[i]  = cpu_bus.bus_read_req & mapped & ~rd_stall &
                              (sel == SEL_BITS'(i));
      end
   end

   assign cpu_bus.bus_ready           = ext_ready[sel] & ~(cpu_bus.bus_read_req & rd_stall);
   assign cpu_bus.bus_read_data       = ext_data[active_slave];
   assign cpu_bus.bus_read_data_valid = ret_valid;

   assign slave_addr        = cpu_bus.bus_addr;
   assign slave_write_data  = cpu_bus.bus_write_data;
   assign slave_byte_enable = cpu_bus.bus_byte_enable;

endmodule

// File: tb/tb_system_bus_router.sv
// Bench for system_bus_router: directed vector table, hand-written
// reset/default-slave sequences and a randomized run against a queue model.
module tb_system_bus_router;
   import system_bus_pkg::*;

   localparam int NS  = 4;
   localparam int MAX = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   // main DUT, four slaves
   system_bus_router_if bus();
   bus_addr_t         s_addr;
   bus_data_t         s_wdata;
   bus_be_t           s_be;
   logic [NS-1:0]     s_wreq, s_rreq, s_ready, s_valid;
   logic [32*NS-1:0]  s_data;

   system_bus_router #(.NUM_SLAVES(NS), .SEL_BITS(2), .MAX_OUTSTANDING(MAX)) u_dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .cpu_bus               (bus),
      .slave_addr            (s_addr),
      .slave_write_data      (s_wdata),
      .slave_byte_enable     (s_be),
      .slave_write_req       (s_wreq),
      .slave_read_req        (s_rreq),
      .slave_ready           (s_ready),
      .slave_read_data       (s_data),
      .slave_read_data_valid (s_valid)
   );

   // second DUT, three slaves, index 3 unmapped
   system_bus_router_if bus3();
   bus_addr_t   t_addr;
   bus_data_t   t_wdata;
   bus_be_t     t_be;
   logic [2:0]  t_wreq, t_rreq, t_ready, t_valid;
   logic [95:0] t_data;

   system_bus_router #(.NUM_SLAVES(3), .SEL_BITS(2), .MAX_OUTSTANDING(MAX)) u_dut3 (
      .clk                   (clk),
      .reset_n               (reset_n),
      .cpu_bus               (bus3),
      .slave_addr            (t_addr),
      .slave_write_data      (t_wdata),
      .slave_byte_enable     (t_be),
      .slave_write_req       (t_wreq),
      .slave_read_req        (t_rreq),
      .slave_ready           (t_ready),
      .slave_read_data       (t_data),
      .slave_read_data_valid (t_valid)
   );

   typedef struct {
      int         sel;
      logic       wr;
      logic       rd;
      logic [3:0] rdy;
      logic [3:0] vld;
      logic       e_ready;
      logic [3:0] e_wreq;
      logic [3:0] e_rreq;
      logic       e_rvalid;
      logic [31:0] e_data;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   logic [29:0] drv_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic wr, input logic rd,
                        input logic [3:0] rdy, input logic [3:0] vld);
      logic [1:0] s2;
      s2 = 2'(sel);
      drv_addr = {s2, 28'($urandom)};
      bus.bus_addr        = drv_addr;
      bus.bus_write_data  = $urandom;
      bus.bus_byte_enable = 4'($urandom);
      bus.bus_write_req   = wr;
      bus.bus_read_req    = rd;
      s_ready = rdy;
      s_valid = vld;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];
   int q[$];
   int sel, op;
   logic [3:0] rdy, vld;
   logic stall, e_ready, ret;
   logic [3:0] e_wreq, e_rreq;

   initial begin
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0, 4'h0, 4'h0);
      s_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hCAFE_BABE};
      bus3.bus_addr = '0; bus3.bus_write_data = '0; bus3.bus_byte_enable = '0;
      bus3.bus_write_req = 1'b0; bus3.bus_read_req = 1'b0;
      t_ready = 3'b000; t_valid = 3'b000; t_data = '1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // ---------------- directed vector table ----------------
      tbl.push_back('{0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{1, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0});
      for (int k = 0; k < 4; k++)
         tbl.push_back('{0, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'hCAFE_BABE});
      tbl.push_back('{0, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 32'h0});
      tbl.push_back('{2, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{2, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0});
      for (int k = 0; k < 4; k++)
         tbl.push_back('{0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'hCAFE_BABE});
      tbl.push_back('{0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 32'hCAFE_BABE});
      tbl.push_back('{2, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0});
      tbl.push_back('{2, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'hCAFE_BABE});
      tbl.push_back('{2, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'hA000_0002});

      for (int r = 0; r < tbl.size(); r++) begin
         drive(tbl[r].sel, tbl[r].wr, tbl[r].rd, tbl[r].rdy, tbl[r].vld);
         #2;
         check($sformatf("tbl%0d.bus_ready", r), 32'(bus.bus_ready), 32'(tbl[r].e_ready));
         check($sformatf("tbl%0d.slave_write_req", r), 32'(s_wreq), 32'(tbl[r].e_wreq));
         check($sformatf("tbl%0d.slave_read_req", r), 32'(s_rreq), 32'(tbl[r].e_rreq));
         check($sformatf("tbl%0d.read_valid", r), 32'(bus.bus_read_data_valid), 32'(tbl[r].e_rvalid));
         if (tbl[r].e_rvalid)
            check($sformatf("tbl%0d.read_data", r), bus.bus_read_data, tbl[r].e_data);
         next_cycle();
      end

      // ---------------- reset in the middle of three outstanding reads ----------------
      for (int k = 0; k < 3; k++) begin
         drive(1, 1'b0, 1'b1, 4'hF, 4'h0);
         #2;
         check($sformatf("rst_pre%0d.bus_ready", k), 32'(bus.bus_ready), 32'd1);
         next_cycle();
      end
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0, 4'h0, 4'h0);
      next_cycle();
      reset_n = 1'b1;
      drive(0, 1'b0, 1'b0, 4'h0, 4'b0011);
      #2;
      check("rst_post.read_valid", 32'(bus.bus_read_data_valid), 32'd0);
      next_cycle();
      drive(3, 1'b0, 1'b1, 4'hF, 4'h0);
      #2;
      check("rst_post.read3_ready", 32'(bus.bus_ready), 32'd1);
      check("rst_post.read3_req", 32'(s_rreq), 32'b1000);
      next_cycle();
      drive(0, 1'b0, 1'b0, 4'h0, 4'b1000);
      #2;
      check("rst_post.ret3_valid", 32'(bus.bus_read_data_valid), 32'd1);
      check("rst_post.ret3_data", bus.bus_read_data, 32'hA000_0003);
      next_cycle();
      drive(0, 1'b0, 1'b0, 4'h0, 4'b1000);
      #2;
      check("rst_post.ret3_extra", 32'(bus.bus_read_data_valid), 32'd0);
      next_cycle();

      // ---------------- unmapped index on the three-slave instance ----------------
      bus3.bus_addr = 30'h3000_0000;
      bus3.bus_read_req = 1'b1;
      t_valid = 3'b111;
`ifdef SYSTEM_BUS_ROUTER_DEFAULT_SLAVE_EN
      t_ready = 3'b000;
      #2;
      check("dflt.c0_ready", 32'(bus3.bus_ready), 32'd1);
      check("dflt.c0_rreq", 32'(t_rreq), 32'd0);
      check("dflt.c0_valid", 32'(bus3.bus_read_data_valid), 32'd0);
      next_cycle();
      #2;
      check("dflt.c1_ready", 32'(bus3.bus_ready), 32'd1);
      check("dflt.c1_valid", 32'(bus3.bus_read_data_valid), 32'd1);
      check("dflt.c1_data", bus3.bus_read_data, 32'h0);
      next_cycle();
      bus3.bus_read_req = 1'b0;
      #2;
      check("dflt.c2_valid", 32'(bus3.bus_read_data_valid), 32'd1);
      check("dflt.c2_data", bus3.bus_read_data, 32'h0);
      next_cycle();
      #2;
      check("dflt.c3_valid", 32'(bus3.bus_read_data_valid), 32'd0);
      bus3.bus_write_req = 1'b1;
      #1;
      check("dflt.wr_ready", 32'(bus3.bus_ready), 32'd1);
      check("dflt.wr_req", 32'(t_wreq), 32'd0);
      next_cycle();
`else
      t_ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         #2;
         check($sformatf("nodflt.c%0d_ready", k), 32'(bus3.bus_ready), 32'd0);
         check($sformatf("nodflt.c%0d_rreq", k), 32'(t_rreq), 32'd0);
         check($sformatf("nodflt.c%0d_valid", k), 32'(bus3.bus_read_data_valid), 32'd0);
         next_cycle();
      end
      bus3.bus_read_req = 1'b0;
      bus3.bus_write_req = 1'b1;
      #2;
      check("nodflt.wr_ready", 32'(bus3.bus_ready), 32'd0);
      check("nodflt.wr_req", 32'(t_wreq), 32'd0);
      next_cycle();
`endif
      bus3.bus_read_req = 1'b0;
      bus3.bus_write_req = 1'b0;

      // ---------------- randomized run against the queue model ----------------
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0, 4'h0, 4'h0);
      next_cycle();
      reset_n = 1'b1;
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         sel = $urandom_range(0, 3);
         op  = $urandom_range(0, 2);
         rdy = 4'($urandom);
         vld = 4'($urandom);
         s_data = {$urandom, $urandom, $urandom, $urandom};
         reset_n = ($urandom_range(0, 63) != 0);
         drive(sel, op == 1, op == 2, rdy, vld);
         #2;
         stall   = (q.size() == MAX) || (q.size() != 0 && q[$] != sel);
         e_ready = (op == 2) ? (rdy[sel] && !stall) : rdy[sel];
         e_wreq  = (op == 1) ? 4'(1 << sel) : 4'b0000;
         e_rreq  = (op == 2 && !stall) ? 4'(1 << sel) : 4'b0000;
         ret     = (q.size() != 0) && vld[q[0]];
         check($sformatf("rnd%0d.bus_ready", c), 32'(bus.bus_ready), 32'(e_ready));
         check($sformatf("rnd%0d.slave_write_req", c), 32'(s_wreq), 32'(e_wreq));
         check($sformatf("rnd%0d.slave_read_req", c), 32'(s_rreq), 32'(e_rreq));
         check($sformatf("rnd%0d.read_valid", c), 32'(bus.bus_read_data_valid), 32'(ret));
         check($sformatf("rnd%0d.slave_addr", c), 32'(s_addr), 32'(drv_addr));
         if (ret)
            check($sformatf("rnd%0d.read_data", c), bus.bus_read_data, s_data[32*q[0] +: 32]);
         next_cycle();
         if (!reset_n) begin
            q.delete();
         end else begin
            if (ret) void'(q.pop_front());
            if (op == 2 && e_ready) q.push_back(sel);
         end
      end
      reset_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
